// File: rtl/booth_pkg.sv
// booth_pkg
//   Shared constants, types and helpers for the Booth product accumulator:
//   default operand width, product-width helper, FSM state encoding and
//   signed saturation limits.
package booth_pkg;

   localparam int BOOTH_WIDTH = 4;

   // Product of two WIDTH-bit signed operands needs 2*WIDTH bits.
   function automatic int prod_width(input int w);
      return 2 * w;
   endfunction

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_DONE  = 1'b1
   } state_t;

   // Largest value representable in an n-bit two's complement number.
   function automatic longint sat_max(input int n);
      return (longint'(1) <<< (n - 1)) - 1;
   endfunction

   // Smallest value representable in an n-bit two's complement number.
   function automatic longint sat_min(input int n);
      return -(longint'(1) <<< (n - 1));
   endfunction

endpackage

// File: rtl/booth_product_accumulator_if.sv
// booth_product_accumulator_if
//   Product input stream (in_valid/in_ready/in_product/in_last) and result
//   output stream (out_valid/out_ready/out_sum/out_terms/out_sat).
//   slave  : the accumulator (consumes products, produces results)
//   master : the environment (produces products, consumes results)
interface booth_product_accumulator_if
   import booth_pkg::*;
#(
   parameter int WIDTH     = BOOTH_WIDTH,
   parameter int ACC_WIDTH = 10,
   parameter int MAX_TERMS = 8
);
   localparam int PW    = prod_width(WIDTH);
   localparam int CNT_W = $clog2(MAX_TERMS + 1);

   logic                        in_valid;
   logic                        in_ready;
   logic signed [PW-1:0]        in_product;
   logic                        in_last;
   logic                        out_valid;
   logic                        out_ready;
   logic signed [ACC_WIDTH-1:0] out_sum;
   logic [CNT_W-1:0]            out_terms;
   logic                        out_sat;

   modport slave (
      input  in_valid, in_product, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_terms, out_sat
   );

   modport master (
      output in_valid, in_product, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_terms, out_sat
   );
endinterface

// File: rtl/booth_sat_add.sv
// booth_sat_add
//   Combinational signed saturating adder.
//   acc    : ACC_WIDTH signed accumulator value
//   addend : ADD_WIDTH signed addend (ADD_WIDTH <= ACC_WIDTH)
//   sum    : acc + addend clamped to the ACC_WIDTH signed range
//   ovf    : high when the clamp was applied
module booth_sat_add
   import booth_pkg::*;
#(
   parameter int ACC_WIDTH = 10,
   parameter int ADD_WIDTH = 8
) (
   input  logic signed [ACC_WIDTH-1:0] acc,
   input  logic signed [ADD_WIDTH-1:0] addend,
   output logic signed [ACC_WIDTH-1:0] sum,
   output logic                        ovf
);
   localparam logic signed [ACC_WIDTH:0] SUM_MAX = (ACC_WIDTH + 1)'(sat_max(ACC_WIDTH));
   localparam logic signed [ACC_WIDTH:0] SUM_MIN = (ACC_WIDTH + 1)'(sat_min(ACC_WIDTH));

   logic signed [ACC_WIDTH:0] wide;

   // One guard bit is enough: both operands fit in ACC_WIDTH bits.
   always_comb begin
      wide = {acc[ACC_WIDTH-1], acc}
           + {{(ACC_WIDTH + 1 - ADD_WIDTH){addend[ADD_WIDTH-1]}}, addend};
      ovf  = 1'b0;
      sum  = wide[ACC_WIDTH-1:0];
      if (wide > SUM_MAX) begin
         sum = SUM_MAX[ACC_WIDTH-1:0];
         ovf = 1'b1;
      end else if (wide < SUM_MIN) begin
         sum = SUM_MIN[ACC_WIDTH-1:0];
         ovf = 1'b1;
      end
   end
endmodule

// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator
//   Sums signed products from the Booth multiplier into groups of up to
//   MAX_TERMS terms with a saturating accumulator and sticky saturation flag.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : product input stream and group result output stream (slave side)
module booth_product_accumulator
   import booth_pkg::*;
#(
   parameter int WIDTH     = BOOTH_WIDTH,
   parameter int ACC_WIDTH = 10,
   parameter int MAX_TERMS = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   booth_product_accumulator_if.slave  bus
);
   localparam int PW    = prod_width(WIDTH);
   localparam int CNT_W = $clog2(MAX_TERMS + 1);

   state_t                      state_q, state_d;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic                        sat_q, sat_d;

   logic signed [ACC_WIDTH-1:0] add_sum;
   logic                        add_ovf;
   logic                        accept;

   booth_sat_add #(
      .ACC_WIDTH (ACC_WIDTH),
      .ADD_WIDTH (PW)
   ) u_sat_add (
      .acc    (acc_q),
      .addend (bus.in_product),
      .sum    (add_sum),
      .ovf    (add_ovf)
   );

   assign accept = bus.in_valid && (state_q == ST_ACCUM);

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      case (state_q)
         ST_ACCUM: begin
            if (accept) begin
               acc_d = add_sum;
               sat_d = sat_q | add_ovf;
               cnt_d = cnt_q + 1'b1;
               if (bus.in_last || (cnt_q == CNT_W'(MAX_TERMS - 1))) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            // Handoff cycle: nothing is accepted, the group is cleared.
            if (bus.out_ready) begin
               acc_d   = '0;
               cnt_d   = '0;
               sat_d   = 1'b0;
               state_d = ST_ACCUM;
            end
         end
         default: state_d = ST_ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
      end
   end

   // Results come straight from the group registers; they only change on
   // accept, handoff or reset, so they hold while out_valid waits.
   assign bus.in_ready  = (state_q == ST_ACCUM) && !rst;
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.out_sum   = acc_q;
   assign bus.out_terms = cnt_q;
   assign bus.out_sat   = sat_q;
endmodule

// File: tb/tb_booth_product_accumulator.sv
// tb_booth_product_accumulator
//   Directed bench for booth_product_accumulator (WIDTH=4, ACC_WIDTH=10,
//   MAX_TERMS=8). Inputs change and outputs are sampled on the falling edge.
module tb_booth_product_accumulator;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nerr = 0;
   int   nchk = 0;

   always #5 clk = ~clk;

   booth_product_accumulator_if #(.WIDTH(4), .ACC_WIDTH(10), .MAX_TERMS(8)) bus ();

   booth_product_accumulator #(.WIDTH(4), .ACC_WIDTH(10), .MAX_TERMS(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input longint obs, input longint exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic v, input longint s,
                          input longint t, input logic sat);
      chk({tag, ".valid"}, longint'(bus.out_valid), longint'(v));
      chk({tag, ".sum"},   longint'(bus.out_sum),   s);
      chk({tag, ".terms"}, longint'(bus.out_terms), t);
      chk({tag, ".sat"},   longint'(bus.out_sat),   longint'(sat));
   endtask

   // Present a product at a falling edge and hold it until accepted at the
   // following rising edge. Returns just after that rising edge.
   task automatic push(input logic signed [7:0] p, input logic l);
      int n = 0;
      @(negedge clk);
      bus.in_valid   = 1'b1;
      bus.in_product = p;
      bus.in_last    = l;
      while (!bus.in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk("push_timeout", 0, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic consume();
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("consume.valid_drop", longint'(bus.out_valid), 0);
      chk("consume.ready_back", longint'(bus.in_ready), 1);
   endtask

   initial begin
      bus.in_valid   = 1'b0;
      bus.in_product = '0;
      bus.in_last    = 1'b0;
      bus.out_ready  = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst.in_ready", longint'(bus.in_ready), 0);
      chk_out("rst", 1'b0, 0, 0, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst.in_ready", longint'(bus.in_ready), 1);

      // 12, -12, -12, 12 with gaps -> 0, 4 terms
      push(8'sd12, 1'b0);
      repeat (2) @(negedge clk);
      push(-8'sd12, 1'b0);
      repeat (2) @(negedge clk);
      chk("g1.mid_sum", longint'(bus.out_sum), 0);
      push(-8'sd12, 1'b0);
      repeat (2) @(negedge clk);
      chk("g1.before_last.valid", longint'(bus.out_valid), 0);
      push(8'sd12, 1'b1);
      @(negedge clk);
      chk_out("g1", 1'b1, 0, 4, 1'b0);
      chk("g1.in_ready", longint'(bus.in_ready), 0);
      consume();

      // 8 x 64 -> auto-close, saturated at 511
      for (int i = 0; i < 7; i++) push(8'sd64, 1'b0);
      @(negedge clk);
      chk("g2.seven.valid", longint'(bus.out_valid), 0);
      chk("g2.seven.sum", longint'(bus.out_sum), 448);
      chk("g2.seven.sat", longint'(bus.out_sat), 0);
      push(8'sd64, 1'b0);
      @(negedge clk);
      chk_out("g2", 1'b1, 511, 8, 1'b1);
      chk("g2.in_ready", longint'(bus.in_ready), 0);
      consume();

      // 8 x -64 -> exactly -512, no saturation
      for (int i = 0; i < 8; i++) push(-8'sd64, 1'b0);
      @(negedge clk);
      chk_out("g3", 1'b1, -512, 8, 1'b0);
      consume();

      // -56 alone, then hold the result while a product waits
      push(-8'sd56, 1'b1);
      @(negedge clk);
      chk_out("g4", 1'b1, -56, 1, 1'b0);
      bus.in_valid   = 1'b1;
      bus.in_product = 8'sd30;
      bus.in_last    = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk_out("g4.hold", 1'b1, -56, 1, 1'b0);
         chk("g4.hold.in_ready", longint'(bus.in_ready), 0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk_out("g4.handoff", 1'b0, 0, 0, 1'b0);
      chk("g4.handoff.in_ready", longint'(bus.in_ready), 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      @(negedge clk);
      chk_out("g5", 1'b1, 30, 1, 1'b0);
      consume();

      // 20, 20, 20 then reset mid-group
      for (int i = 0; i < 3; i++) push(8'sd20, 1'b0);
      @(negedge clk);
      chk("g6.partial", longint'(bus.out_sum), 60);
      rst = 1'b1;
      @(negedge clk);
      chk("g6.rst.in_ready", longint'(bus.in_ready), 0);
      rst = 1'b0;
      chk_out("g6.rst", 1'b0, 0, 0, 1'b0);
      push(8'sd14, 1'b1);
      @(negedge clk);
      chk_out("g7", 1'b1, 14, 1, 1'b0);
      consume();

      // Saturated group, then a clean group: sat flag must not persist
      for (int i = 0; i < 8; i++) push(8'sd64, 1'b0);
      @(negedge clk);
      chk_out("g8", 1'b1, 511, 8, 1'b1);
      consume();
      push(8'sd5, 1'b1);
      @(negedge clk);
      chk_out("g9", 1'b1, 5, 1, 1'b0);
      consume();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
